// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with hard-wired zero register, optional
// write-to-read forwarding and per-register busy scoreboard. Debug taps: REGFILE_SB_DBG_EN.

module regfile_sb_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0]                      ra,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     regs,
    input  logic [(2**ADDR_W)-1:0]                 busy,
    input  logic                                   we,
    input  logic [ADDR_W-1:0]                      wa,
    input  logic [DATA_W-1:0]                      wd,
    output logic [DATA_W-1:0]                      rd,
    output logic                                   rbusy
);
    logic w_zero;
    logic w_fwd;

    assign w_zero = (ra == '0);
    // Forwarding never targets r0, so a write to r0 cannot leak onto a read.
    assign w_fwd  = (BYPASS != 0) && we && (wa == ra) && !w_zero;

    always_comb begin
        rd    = regs[ra];
        rbusy = busy[ra] & ~w_fwd;
        if (w_zero) begin
            rd    = '0;
            rbusy = 1'b0;
        end else if (w_fwd) begin
            rd    = wd;
        end
    end
endmodule

module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  busy1,
    output logic                  busy2,
`ifdef REGFILE_SB_DBG_EN
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [(2**ADDR_W)-1:0] dbg_busy,
`endif
    output logic                  iss_busy
);
    localparam int NREG   = 2**ADDR_W;
    localparam int NPORTS = 2;

    logic [NREG-1:0][DATA_W-1:0]   r_regs;
    logic [NREG-1:0]               r_busy;

    logic                          w_wr;
    logic                          w_iss;
    logic [NPORTS-1:0][ADDR_W-1:0] w_ra;
    logic [NPORTS-1:0][DATA_W-1:0] w_rd;
    logic [NPORTS-1:0]             w_rbusy;

    assign w_wr  = we && (wa != '0);
    assign w_iss = iss_en && (iss_addr != '0);

    // r_regs[0] is cleared in reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (w_wr) begin
            r_regs[wa] <= wd;
        end
    end

    // Issue is applied after writeback so a new producer outranks the completing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr)
                r_busy[wa] <= 1'b0;
            if (w_iss)
                r_busy[iss_addr] <= 1'b1;
        end
    end

    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        regfile_sb_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rdport (
            .ra    (w_ra[p]),
            .regs  (r_regs),
            .busy  (r_busy),
            .we    (we),
            .wa    (wa),
            .wd    (wd),
            .rd    (w_rd[p]),
            .rbusy (w_rbusy[p])
        );
    end

    assign rd1      = w_rd[0];
    assign rd2      = w_rd[1];
    assign busy1    = w_rbusy[0];
    assign busy2    = w_rbusy[1];
    assign iss_busy = r_busy[iss_addr];

`ifdef REGFILE_SB_DBG_EN
    assign dbg_data = r_regs[dbg_addr];
    assign dbg_busy = r_busy;
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb; runs BYPASS=1 and BYPASS=0 instances
// side by side against one architectural model. Debug taps checked under REGFILE_SB_DBG_EN.

module tb_regfile_sb;
    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, iss_addr;
    logic        we, iss_en;
    logic [31:0] wd;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy1_b, busy2_b, ibusy_b, busy1_n, busy2_n, ibusy_n;
`ifdef REGFILE_SB_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data_b, dbg_data_n, dbg_busy_b, dbg_busy_n;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
        .busy1(busy1_b), .busy2(busy2_b),
`ifdef REGFILE_SB_DBG_EN
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .dbg_busy(dbg_busy_b),
`endif
        .iss_busy(ibusy_b));

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
        .busy1(busy1_n), .busy2(busy2_n),
`ifdef REGFILE_SB_DBG_EN
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_n), .dbg_busy(dbg_busy_n),
`endif
        .iss_busy(ibusy_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'd0;
        if (byp && we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic m_bsy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(byp && we && wa == a);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_busy = 32'd0;
    endtask

    task automatic m_upd();
        if (we && wa != 0) begin
            m_mem[wa]    = wd;
            m_busy[wa]   = 1'b0;
        end
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd1_b"},  rd1_b,   m_rd(ra1, 1));
        chk({tag, ".rd2_b"},  rd2_b,   m_rd(ra2, 1));
        chk({tag, ".rd1_n"},  rd1_n,   m_rd(ra1, 0));
        chk({tag, ".rd2_n"},  rd2_n,   m_rd(ra2, 0));
        chk({tag, ".bsy1_b"}, {31'd0, busy1_b}, {31'd0, m_bsy(ra1, 1)});
        chk({tag, ".bsy2_b"}, {31'd0, busy2_b}, {31'd0, m_bsy(ra2, 1)});
        chk({tag, ".bsy1_n"}, {31'd0, busy1_n}, {31'd0, m_bsy(ra1, 0)});
        chk({tag, ".bsy2_n"}, {31'd0, busy2_n}, {31'd0, m_bsy(ra2, 0)});
        chk({tag, ".ibsy_b"}, {31'd0, ibusy_b}, {31'd0, m_busy[iss_addr]});
        chk({tag, ".ibsy_n"}, {31'd0, ibusy_n}, {31'd0, m_busy[iss_addr]});
`ifdef REGFILE_SB_DBG_EN
        chk({tag, ".dbgd_b"}, dbg_data_b, m_mem[dbg_addr]);
        chk({tag, ".dbgd_n"}, dbg_data_n, m_mem[dbg_addr]);
        chk({tag, ".dbgb_b"}, dbg_busy_b, m_busy);
        chk({tag, ".dbgb_n"}, dbg_busy_n, m_busy);
`endif
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (rst_n) m_upd();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; iss_en = 1'b0; wa = '0; wd = '0; iss_addr = '0;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        ra1 = 5'd3; ra2 = 5'd17;
`ifdef REGFILE_SB_DBG_EN
        dbg_addr = 5'd3;
`endif
        m_clear();
        #2;
        check_all("reset0");
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // basic write then read on both ports
        we = 1; wa = 5; wd = 32'h12345678; ra1 = 0; ra2 = 0;
        cyc("wr5");
        idle(); ra1 = 5; ra2 = 5;
        #1;
        chk("basic.rd1", rd1_b, 32'h12345678);
        chk("basic.rd2", rd2_b, 32'h12345678);
        chk("basic.rd2n", rd2_n, 32'h12345678);
        cyc("rd5");

        // zero register ignores writes and issue
        we = 1; wa = 0; wd = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; ra1 = 0;
        cyc("wr0");
        idle(); ra1 = 0;
        #1;
        chk("zero.rd1", rd1_b, 32'd0);
        chk("zero.bsy1", {31'd0, busy1_b}, 32'd0);
        cyc("rd0");

        // same-cycle forwarding vs none
        ra1 = 7; we = 1; wa = 7; wd = 32'hA5A5A5A5;
        #1;
        chk("fwd.rd1_b", rd1_b, 32'hA5A5A5A5);
        chk("fwd.rd1_n", rd1_n, 32'd0);
        cyc("fwd");
        idle(); ra1 = 7;
        #1 chk("fwd.next_n", rd1_n, 32'hA5A5A5A5);
        cyc("fwd2");

        // scoreboard set then clear via writeback
        iss_en = 1; iss_addr = 9;
        cyc("iss9");
        idle(); ra1 = 9; iss_addr = 9;
        #1;
        chk("sb.bsy1", {31'd0, busy1_b}, 32'd1);
        chk("sb.ibsy", {31'd0, ibusy_b}, 32'd1);
        cyc("sb1");
        we = 1; wa = 9; wd = 32'h00000099; ra1 = 9; iss_addr = 9;
        #1;
        chk("sb.fwdclr_b", {31'd0, busy1_b}, 32'd0);
        chk("sb.fwdclr_n", {31'd0, busy1_n}, 32'd1);
        chk("sb.ibsy_nomask", {31'd0, ibusy_b}, 32'd1);
        cyc("sb2");
        idle(); ra1 = 9;
        #1 chk("sb.clr", {31'd0, busy1_n}, 32'd0);
        cyc("sb3");

        // simultaneous set and clear on r4: set wins, data still written
        iss_en = 1; iss_addr = 4;
        cyc("iss4");
        we = 1; wa = 4; wd = 32'hCAFEF00D; iss_en = 1; iss_addr = 4; ra1 = 4;
        cyc("setclr");
        idle(); ra1 = 4; iss_addr = 4;
`ifdef REGFILE_SB_DBG_EN
        dbg_addr = 4;
`endif
        #1;
        chk("sc.rd1", rd1_b, 32'hCAFEF00D);
        chk("sc.bsy1", {31'd0, busy1_b}, 32'd1);
        chk("sc.ibsy", {31'd0, ibusy_b}, 32'd1);
`ifdef REGFILE_SB_DBG_EN
        chk("sc.dbgb4", {31'd0, dbg_busy_b[4]}, 32'd1);
        chk("sc.dbgd", dbg_data_b, 32'hCAFEF00D);
`endif
        cyc("sc2");

        // randomized traffic concentrated on a few registers for frequent hazards
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = raddr();
            wd = $urandom;
            iss_en = 1'($urandom_range(0, 1));
            iss_addr = raddr();
            ra1 = raddr();
            ra2 = ($urandom_range(0, 4) == 0) ? ra1 : raddr();
`ifdef REGFILE_SB_DBG_EN
            dbg_addr = raddr();
`endif
            cyc("rnd");
        end

        // asynchronous reset mid-cycle
        we = 1; wa = 3; wd = 32'hDEADBEEF; iss_en = 1; iss_addr = 3;
        cyc("wr3");
        idle(); ra1 = 3; iss_addr = 3;
        #1;
        chk("pre.rd1", rd1_b, 32'hDEADBEEF);
        chk("pre.bsy1", {31'd0, busy1_b}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.rd1_b", rd1_b, 32'd0);
        chk("arst.rd1_n", rd1_n, 32'd0);
        chk("arst.bsy1", {31'd0, busy1_b}, 32'd0);
        chk("arst.ibsy", {31'd0, ibusy_b}, 32'd0);
        m_clear();
        @(negedge clk);
        check_all("inrst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = raddr();
            wd = $urandom;
            iss_en = 1'($urandom_range(0, 1));
            iss_addr = raddr();
            ra1 = raddr();
            ra2 = raddr();
            cyc("post");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
